// File: rtl/router_reg_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : router_reg_gen_if
//  Description : Bus bundle between the router FSM/input side and the packet
//                datapath register: byte stream, FSM state decodes and the
//                register's data/status outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface router_reg_gen_if #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
);
    logic             pkt_valid;
    logic [DW-1:0]    data_in;
    logic             fifo_full;
    logic             rst_int_reg;
    logic             detect_add;
    logic             lfd_state;
    logic             ld_state;
    logic             laf_state;
    logic             full_state;
    logic [DW-1:0]    dout;
    logic             parity_done;
    logic             low_pkt_valid;
    logic             err;
    logic             len_err;
    logic [CNT_W-1:0] good_cnt;

    // Source / FSM side: drives the byte stream and state decodes
    modport master (
        output pkt_valid, data_in, fifo_full, rst_int_reg, detect_add,
               lfd_state, ld_state, laf_state, full_state,
        input  dout, parity_done, low_pkt_valid, err, len_err, good_cnt
    );

    // Datapath register side
    modport slave (
        input  pkt_valid, data_in, fifo_full, rst_int_reg, detect_add,
               lfd_state, ld_state, laf_state, full_state,
        output dout, parity_done, low_pkt_valid, err, len_err, good_cnt
    );
endinterface
`default_nettype wire

// File: rtl/router_reg_gen.sv
`default_nettype none
// ============================================================================
//  Module      : router_reg_gen
//  Description : Packet datapath register for the 1xN router. Latches the
//                header, buffers the byte arriving while the FIFO is full,
//                accumulates running parity, checks parity and payload length
//                and counts good packets.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_reg_gen #(
    parameter int DW          = 8,
    parameter int ADDR_W      = 2,
    parameter int NUM_PORTS   = 3,
    parameter int PARITY_MODE = 0,
    parameter int CNT_W       = 16
) (
    input  wire logic       clock,
    input  wire logic       resetn,
    router_reg_gen_if.slave bus
);
    localparam int                c_LW     = DW - ADDR_W;
    localparam logic [ADDR_W:0]   c_NPORTS = NUM_PORTS[ADDR_W:0];

    logic [DW-1:0]    r_dout;
    logic [DW-1:0]    r_hold;
    logic             r_hold_par;
    logic [DW-1:0]    r_hdr;
    logic [c_LW-1:0]  r_exp_len;
    logic [DW-1:0]    r_ip;
    logic [DW-1:0]    r_pp;
    logic [c_LW-1:0]  r_cnt;
    logic             r_parity_done;
    logic             r_parity_done_q;
    logic             r_low_pkt_valid;
    logic             r_err;
    logic             r_len_err;
    logic [CNT_W-1:0] r_good_cnt;

    logic w_addr_ok;
    logic w_cap_ld;
    logic w_cap_laf;
    logic w_check;
    logic w_unused;

    // full_state is only a wait state: the register simply holds through it
    assign w_unused  = bus.full_state;

    assign w_addr_ok = ({1'b0, bus.data_in[ADDR_W-1:0]} < c_NPORTS);
    // ld_state wins over a (never legal) simultaneous laf_state
    assign w_cap_ld  = bus.ld_state & ~bus.pkt_valid & ~bus.fifo_full;
    assign w_cap_laf = ~bus.ld_state & bus.laf_state & r_hold_par;
    // Checks run exactly once, on the cycle after parity_done rises
    assign w_check   = r_parity_done & ~r_parity_done_q;

    function automatic logic [DW-1:0] f_op(input logic [DW-1:0] acc, input logic [DW-1:0] d);
        if (PARITY_MODE == 0) f_op = acc ^ d;
        else                  f_op = {acc[DW-2:0], acc[DW-1]} ^ d;
    endfunction

    // Header latch; an out-of-range address leaves the previous header in place
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_hdr     <= '0;
            r_exp_len <= '0;
        end else if (bus.detect_add && bus.pkt_valid && w_addr_ok) begin
            r_hdr     <= bus.data_in;
            r_exp_len <= bus.data_in[DW-1:ADDR_W];
        end
    end

    // Output byte select: header, live byte, or the byte held during full
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_dout <= '0;
        end else if (bus.lfd_state) begin
            r_dout <= r_hdr;
        end else if (bus.ld_state) begin
            if (!bus.fifo_full) r_dout <= bus.data_in;
        end else if (bus.laf_state) begin
            r_dout <= r_hold;
        end
    end

    // Capture the byte presented while the FIFO is full, tagging parity bytes
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_hold     <= '0;
            r_hold_par <= 1'b0;
        end else if (bus.ld_state && bus.fifo_full) begin
            r_hold     <= bus.data_in;
            r_hold_par <= ~bus.pkt_valid;
        end
    end

    // Running parity and payload byte count
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_ip  <= '0;
            r_cnt <= '0;
        end else if (bus.detect_add) begin
            r_ip <= '0;
        end else if (bus.lfd_state) begin
            r_ip <= f_op('0, r_hdr);
        end else if (bus.ld_state) begin
            if (bus.pkt_valid && !bus.fifo_full) begin
                r_ip  <= f_op(r_ip, bus.data_in);
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (bus.laf_state) begin
            if (!r_hold_par && !r_parity_done) begin
                r_ip  <= f_op(r_ip, r_hold);
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (bus.rst_int_reg && !bus.pkt_valid) begin
            r_ip  <= '0;
            r_cnt <= '0;
        end
    end

    // Packet parity byte capture; a capture beats a header-decode clear
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_pp            <= '0;
            r_parity_done   <= 1'b0;
            r_parity_done_q <= 1'b0;
        end else begin
            r_parity_done_q <= r_parity_done;
            if (w_cap_ld) begin
                r_pp          <= bus.data_in;
                r_parity_done <= 1'b1;
            end else if (w_cap_laf) begin
                r_pp          <= r_hold;
                r_parity_done <= 1'b1;
            end else if (bus.detect_add) begin
                r_pp          <= '0;
                r_parity_done <= 1'b0;
            end
        end
    end

    // Flag the source dropping pkt_valid while loading data
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_low_pkt_valid <= 1'b0;
        end else if (bus.rst_int_reg) begin
            r_low_pkt_valid <= 1'b0;
        end else if (bus.ld_state && !bus.pkt_valid) begin
            r_low_pkt_valid <= 1'b1;
        end
    end

    // End-of-packet checks and saturating good-packet counter
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_err      <= 1'b0;
            r_len_err  <= 1'b0;
            r_good_cnt <= '0;
        end else if (w_check) begin
            r_err     <= (r_ip != r_pp);
            r_len_err <= (r_cnt != r_exp_len);
            if ((r_ip == r_pp) && (r_cnt == r_exp_len) && !(&r_good_cnt))
                r_good_cnt <= r_good_cnt + 1'b1;
        end else if (bus.detect_add) begin
            r_err     <= 1'b0;
            r_len_err <= 1'b0;
        end
    end

    assign bus.dout          = r_dout;
    assign bus.parity_done   = r_parity_done;
    assign bus.low_pkt_valid = r_low_pkt_valid;
    assign bus.err           = r_err;
    assign bus.len_err       = r_len_err;
    assign bus.good_cnt      = r_good_cnt;
endmodule
`default_nettype wire

// File: tb/tb_router_reg_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_reg_gen
//  Description : Bench for router_reg_gen. One stimulus stream drives an XOR
//                instance and a rotate-XOR instance; a packet-level model
//                predicts the output bytes, flags and good-packet counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_reg_gen;
    logic       clock;
    logic       resetn;
    logic       pkt_valid, fifo_full, rst_int_reg, detect_add;
    logic       lfd_state, ld_state, laf_state, full_state;
    logic [7:0] data_in;

    int checks   = 0;
    int failures = 0;

    router_reg_gen_if #(.DW(8), .CNT_W(16)) bus0 ();
    router_reg_gen_if #(.DW(8), .CNT_W(16)) bus1 ();

    assign bus0.pkt_valid = pkt_valid;    assign bus1.pkt_valid = pkt_valid;
    assign bus0.data_in = data_in;        assign bus1.data_in = data_in;
    assign bus0.fifo_full = fifo_full;    assign bus1.fifo_full = fifo_full;
    assign bus0.rst_int_reg = rst_int_reg; assign bus1.rst_int_reg = rst_int_reg;
    assign bus0.detect_add = detect_add;  assign bus1.detect_add = detect_add;
    assign bus0.lfd_state = lfd_state;    assign bus1.lfd_state = lfd_state;
    assign bus0.ld_state = ld_state;      assign bus1.ld_state = ld_state;
    assign bus0.laf_state = laf_state;    assign bus1.laf_state = laf_state;
    assign bus0.full_state = full_state;  assign bus1.full_state = full_state;

    router_reg_gen #(.DW(8), .ADDR_W(2), .NUM_PORTS(3), .PARITY_MODE(0), .CNT_W(16)) u_dut0 (
        .clock(clock), .resetn(resetn), .bus(bus0));
    router_reg_gen #(.DW(8), .ADDR_W(2), .NUM_PORTS(3), .PARITY_MODE(1), .CNT_W(16)) u_dut1 (
        .clock(clock), .resetn(resetn), .bus(bus1));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packet description and model state
    logic [7:0] hdr_b;
    logic [7:0] pay [0:7];
    logic [7:0] par_b;
    int         npay;
    int         fmask;
    logic [7:0] m_hdr;
    logic [7:0] m_dout;
    int         m_good [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_ctl();
        pkt_valid = 0; fifo_full = 0; rst_int_reg = 0; detect_add = 0;
        lfd_state = 0; ld_state = 0; laf_state = 0; full_state = 0;
    endtask

    // Parity of header + payload under either accumulation rule
    function automatic logic [7:0] model_par(input int mode, input logic [7:0] h);
        int acc = int'(h);
        for (int i = 0; i < npay; i++) begin
            if (mode == 0) acc = acc ^ int'(pay[i]);
            else           acc = (((acc * 2) + (acc / 128)) % 256) ^ int'(pay[i]);
        end
        return acc[7:0];
    endfunction

    task automatic chk_dout(input string tag);
        chk({tag, "_dout0"}, {24'd0, bus0.dout}, {24'd0, m_dout});
        chk({tag, "_dout1"}, {24'd0, bus1.dout}, {24'd0, m_dout});
    endtask

    // Drive one packet through the FSM-style sequence and check it
    task automatic run_pkt();
        logic       valid;
        logic       e0, e1, le;
        logic [7:0] p0, p1;
        valid = (hdr_b[1:0] < 2'd3);
        idle_ctl(); detect_add = 1; pkt_valid = 1; data_in = hdr_b;
        step();
        if (valid) m_hdr = hdr_b;
        chk("hdr_pdone", {31'd0, bus0.parity_done}, 0);
        chk("hdr_err0", {31'd0, bus0.err}, 0);
        chk("hdr_lerr1", {31'd0, bus1.len_err}, 0);
        idle_ctl(); lfd_state = 1; pkt_valid = 1; data_in = 8'($urandom);
        step();
        m_dout = m_hdr;
        chk_dout("lfd");
        if (!valid) return;
        for (int i = 0; i < npay; i++) begin
            idle_ctl(); ld_state = 1; pkt_valid = 1; data_in = pay[i]; fifo_full = fmask[i];
            step();
            if (!fmask[i]) m_dout = pay[i];
            chk_dout("ld");
            if (fmask[i]) begin
                idle_ctl(); full_state = 1; pkt_valid = 1; fifo_full = 1; data_in = 8'($urandom);
                step();
                chk_dout("full");
                idle_ctl(); laf_state = 1; pkt_valid = 1; data_in = 8'($urandom);
                step();
                m_dout = pay[i];
                chk_dout("laf");
            end
        end
        idle_ctl(); ld_state = 1; pkt_valid = 0; data_in = par_b; fifo_full = fmask[npay];
        step();
        chk("par_low", {31'd0, bus0.low_pkt_valid}, 1);
        if (fmask[npay]) begin
            chk("par_pdone_wait", {31'd0, bus1.parity_done}, 0);
            idle_ctl(); laf_state = 1; data_in = 8'($urandom);
            step();
        end
        m_dout = par_b;
        chk_dout("par");
        chk("par_pdone0", {31'd0, bus0.parity_done}, 1);
        p0 = model_par(0, m_hdr);
        p1 = model_par(1, m_hdr);
        e0 = (p0 != par_b);
        e1 = (p1 != par_b);
        le = ((npay % 64) != int'(m_hdr[7:2]));
        if (!e0 && !le) m_good[0]++;
        if (!e1 && !le) m_good[1]++;
        idle_ctl(); rst_int_reg = 1; pkt_valid = 0;
        step();
        chk("chk_err0", {31'd0, bus0.err}, {31'd0, e0});
        chk("chk_err1", {31'd0, bus1.err}, {31'd0, e1});
        chk("chk_lerr0", {31'd0, bus0.len_err}, {31'd0, le});
        chk("chk_lerr1", {31'd0, bus1.len_err}, {31'd0, le});
        chk("chk_good0", {16'd0, bus0.good_cnt}, m_good[0]);
        chk("chk_good1", {16'd0, bus1.good_cnt}, m_good[1]);
        chk("chk_low", {31'd0, bus0.low_pkt_valid}, 0);
        idle_ctl();
        step();
        chk("sticky_err0", {31'd0, bus0.err}, {31'd0, e0});
        chk("sticky_lerr1", {31'd0, bus1.len_err}, {31'd0, le});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout0"}, {24'd0, bus0.dout}, 0);
        chk({tag, "_dout1"}, {24'd0, bus1.dout}, 0);
        chk({tag, "_pdone"}, {30'd0, bus0.parity_done, bus1.parity_done}, 0);
        chk({tag, "_low"}, {30'd0, bus0.low_pkt_valid, bus1.low_pkt_valid}, 0);
        chk({tag, "_err"}, {28'd0, bus0.err, bus1.err, bus0.len_err, bus1.len_err}, 0);
        chk({tag, "_good"}, {bus0.good_cnt, bus1.good_cnt}, 0);
    endtask

    initial begin
        idle_ctl();
        data_in = 8'h00;
        resetn  = 0;
        m_hdr = 8'h00; m_dout = 8'h00; m_good[0] = 0; m_good[1] = 0;
        step(); step();
        chk_all_zero("reset");
        resetn = 1;

        // Reference packet: hdr 0D (addr1, len3), payload 11 22 33, parity 0D
        hdr_b = 8'h0D; npay = 3; pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        par_b = 8'h0D; fmask = 0;
        run_pkt();
        chk("spec_good_first", {16'd0, bus0.good_cnt}, 1);

        // Wrong parity byte
        par_b = 8'h0E;
        run_pkt();
        chk("spec_err_bad_par", {31'd0, bus0.err}, 1);

        // FIFO full on the 0x22 payload byte
        par_b = 8'h0D; fmask = 32'h2;
        run_pkt();
        chk("spec_full_err", {31'd0, bus0.err}, 0);

        // Out-of-range address keeps the previous header
        hdr_b = 8'h07; fmask = 0;
        run_pkt();
        chk("spec_bad_addr_hdr", {24'd0, bus0.dout}, 32'h0D);

        // Short packet with correct parity
        hdr_b = 8'h0D; npay = 2; par_b = 8'h3E;
        run_pkt();
        chk("spec_short_lerr", {31'd0, bus0.len_err}, 1);
        chk("spec_short_err", {31'd0, bus0.err}, 0);

        // Rotate-XOR reference: hdr 05, payload 01 -> parity 0B
        hdr_b = 8'h05; npay = 1; pay[0] = 8'h01; par_b = 8'h0B;
        run_pkt();
        chk("spec_rot_err1", {31'd0, bus1.err}, 0);
        chk("spec_rot_err0", {31'd0, bus0.err}, 1);

        // Parity byte itself arriving while the FIFO is full
        hdr_b = 8'h09; npay = 2; pay[0] = 8'hA5; pay[1] = 8'h3C; fmask = 32'h5;
        par_b = model_par(0, hdr_b);
        run_pkt();

        // Randomised packets
        for (int k = 0; k < 24; k++) begin
            int sel;
            npay = int'($urandom_range(0, 6));
            for (int i = 0; i < npay; i++) pay[i] = 8'($urandom);
            hdr_b[1:0] = 2'($urandom_range(0, 3));
            hdr_b[7:2] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 7)) : 6'(npay);
            fmask = int'($urandom_range(0, 255));
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      par_b = model_par(0, hdr_b);
            else if (sel == 1) par_b = model_par(1, hdr_b);
            else               par_b = 8'($urandom);
            run_pkt();
        end

        // Reset in the middle of a packet abandons it
        idle_ctl(); detect_add = 1; pkt_valid = 1; data_in = 8'h0D; step();
        idle_ctl(); lfd_state = 1; pkt_valid = 1; step();
        idle_ctl(); ld_state = 1; pkt_valid = 1; data_in = 8'h11; step();
        resetn = 0;
        step();
        chk_all_zero("midreset");
        resetn = 1;
        m_hdr = 8'h00; m_dout = 8'h00; m_good[0] = 0; m_good[1] = 0;

        hdr_b = 8'h0D; npay = 3; pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        par_b = 8'h0D; fmask = 0;
        run_pkt();
        chk("post_reset_good", {16'd0, bus0.good_cnt}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
